// File: rtl/quotient_pixel_fifo.sv
// quotient_pixel_fifo: clamps signed divider quotients to unsigned pixels
// and buffers them in a first-word-fall-through FIFO with line framing.
//
// Ports:
//   clock, reset  : single clock, synchronous active-high reset
//   in_valid      : quotient strobe from the divider (no backpressure)
//   in_quotient   : two's-complement quotient
//   almost_full   : registered advisory, fill_count >= DEPTH-SLACK
//   out_valid     : pixel available at the head of the FIFO
//   out_ready     : downstream accept
//   out_pixel     : clamped pixel at the read pointer
//   out_last      : head pixel is the last of its line
//   fill_count    : occupied entries
//   overflow      : sticky flag, set when a push is dropped on a full FIFO
module quotient_pixel_fifo #(
    parameter int QUOTIENT_WIDTH = 12,
    parameter int PIXEL_WIDTH    = 8,
    parameter int DEPTH          = 32,
    parameter int SLACK          = 14,
    parameter int IMAGE_WIDTH    = 720
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [QUOTIENT_WIDTH-1:0] in_quotient,
    output logic                      almost_full,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PIXEL_WIDTH-1:0]    out_pixel,
    output logic                      out_last,
    output logic [$clog2(DEPTH):0]    fill_count,
    output logic                      overflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int COLW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

    localparam logic [CW-1:0]             DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]             AF_LEVEL = CW'(DEPTH - SLACK);
    localparam logic [COLW-1:0]           COL_LAST = COLW'(IMAGE_WIDTH - 1);
    localparam logic [QUOTIENT_WIDTH-1:0] PIX_MAX_Q =
        QUOTIENT_WIDTH'((1 << PIXEL_WIDTH) - 1);

    logic [PIXEL_WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [COLW-1:0] col_q, col_d;
    logic            ovf_q, ovf_d;
    logic            af_q, af_d;

    logic                   push;
    logic                   pop;
    logic                   accept;
    logic [PIXEL_WIDTH-1:0] pix;

    // Clamp: negative -> 0, above pixel range -> saturate.
    always_comb begin
        pix = in_quotient[PIXEL_WIDTH-1:0];
        if (in_quotient[QUOTIENT_WIDTH-1]) begin
            pix = '0;
        end else if (in_quotient > PIX_MAX_Q) begin
            pix = '1;
        end
    end

    always_comb begin
        push   = in_valid;
        pop    = (count_q != '0) && out_ready;
        // Fullness is judged before any pop this cycle, so a push at
        // full is dropped even when a pop frees a slot.
        accept = push && (count_q != DEPTH_C);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        col_d    = col_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            col_d    = (col_q == COL_LAST) ? '0 : col_q + COLW'(1);
        end

        unique case ({accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        ovf_d = ovf_q | (push & ~accept);
        af_d  = (count_q >= AF_LEVEL);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            col_q    <= '0;
            ovf_q    <= 1'b0;
            af_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            col_q    <= col_d;
            ovf_q    <= ovf_d;
            af_q     <= af_d;
        end
    end

    // Storage is not reset; contents are only visible while out_valid.
    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            mem_q[wr_ptr_q] <= pix;
        end
    end

    assign out_valid   = (count_q != '0);
    assign out_pixel   = mem_q[rd_ptr_q];
    assign out_last    = out_valid && (col_q == COL_LAST);
    assign fill_count  = count_q;
    assign overflow    = ovf_q;
    assign almost_full = af_q;

endmodule

// File: tb/tb_quotient_pixel_fifo.sv
// Self-checking bench for quotient_pixel_fifo using a queue-based
// reference model and directed plus random stimulus.
module tb_quotient_pixel_fifo;

    localparam int QW    = 12;
    localparam int PW    = 8;
    localparam int DEPTH = 32;
    localparam int SLACK = 14;
    localparam int IW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [QW-1:0] in_quotient = '0;
    logic          almost_full;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_pixel;
    logic          out_last;
    logic [5:0]    fill_count;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    int m_q[$];
    int m_col = 0;
    bit m_ovf = 0;
    bit m_af  = 0;

    quotient_pixel_fifo #(
        .QUOTIENT_WIDTH(QW),
        .PIXEL_WIDTH(PW),
        .DEPTH(DEPTH),
        .SLACK(SLACK),
        .IMAGE_WIDTH(IW)
    ) dut (
        .clock(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_quotient(in_quotient),
        .almost_full(almost_full),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pixel(out_pixel),
        .out_last(out_last),
        .fill_count(fill_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic int clamp(input logic [QW-1:0] q);
        int s;
        s = int'($signed(q));
        if (s < 0) return 0;
        if (s > (1 << PW) - 1) return (1 << PW) - 1;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit v;
        v = (m_q.size() != 0);
        chk("fill_count", 32'(fill_count), 32'(m_q.size()));
        chk("out_valid", 32'(out_valid), 32'(v));
        chk("out_last", 32'(out_last), 32'(v && m_col == IW - 1));
        chk("almost_full", 32'(almost_full), 32'(m_af));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (v) chk("out_pixel", 32'(out_pixel), 32'(m_q[0]));
    endtask

    // One clock: drive inputs, advance the model at the edge, then check.
    task automatic step(input bit v, input logic [QW-1:0] q,
                        input bit r, input bit rst);
        bit full;
        bit pop;
        bit af_n;
        in_valid    = v;
        in_quotient = q;
        out_ready   = r;
        reset       = rst;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_col = 0;
            m_ovf = 0;
            m_af  = 0;
        end else begin
            full = (m_q.size() == DEPTH);
            pop  = (m_q.size() != 0) && r;
            af_n = (m_q.size() >= DEPTH - SLACK);
            if (pop) begin
                void'(m_q.pop_front());
                m_col = (m_col + 1) % IW;
            end
            if (v) begin
                if (full) m_ovf = 1;
                else m_q.push_back(clamp(q));
            end
            m_af = af_n;
        end
        #1;
        check_all();
    endtask

    function automatic logic [QW-1:0] rq();
        return QW'($urandom);
    endfunction

    initial begin
        logic [QW-1:0] cq [6];
        int saw_af;
        cq[0] = QW'(-5);
        cq[1] = QW'(0);
        cq[2] = QW'(100);
        cq[3] = QW'(255);
        cq[4] = QW'(256);
        cq[5] = QW'(2047);

        #1;
        step(0, '0, 0, 1);
        step(0, '0, 0, 0);

        // Clamp sequence, streaming with out_ready high.
        for (int i = 0; i < 6; i++) step(1, cq[i], 1, 0);
        step(0, '0, 1, 0);

        // Backpressure: almost_full lags the 18th entry by one cycle.
        step(0, '0, 0, 1);
        for (int i = 0; i < 18; i++) step(1, rq(), 0, 0);
        chk("af_not_yet", 32'(almost_full), 32'(0));
        step(0, '0, 0, 0);
        chk("af_risen", 32'(almost_full), 32'(1));

        // Overflow: 33 pushes into an empty FIFO, then drain.
        step(0, '0, 0, 1);
        for (int i = 0; i < 33; i++) step(1, rq(), 0, 0);
        chk("ovf_count", 32'(fill_count), 32'(32));
        chk("ovf_flag", 32'(overflow), 32'(1));
        // Drop while popping at full.
        step(1, rq(), 1, 0);
        chk("ovf_drop_pop", 32'(fill_count), 32'(31));
        for (int i = 0; i < 24; i++) step(0, '0, 1, 0);
        chk("pre_reset_cnt", 32'(fill_count), 32'(7));

        // Reset mid-stream with a push pending.
        step(1, rq(), 1, 1);
        chk("rst_cnt", 32'(fill_count), 32'(0));
        chk("rst_ovf", 32'(overflow), 32'(0));
        chk("rst_valid", 32'(out_valid), 32'(0));

        // Line framing from column 0 after reset: last on pixels 4 and 8.
        for (int i = 0; i < 10; i++) step(1, rq(), 1, 0);
        step(0, '0, 1, 0);

        // Simultaneous push/pop holding at five entries.
        step(0, '0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, rq(), 0, 0);
        for (int i = 0; i < 10; i++) step(1, rq(), 1, 0);
        chk("hold5", 32'(fill_count), 32'(5));

        // Pop on empty must not move anything.
        step(0, '0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0);
        step(1, 12'd7, 0, 0);

        // Random traffic biased toward filling to exercise wrap and flags.
        saw_af = 0;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 60, rq(),
                 $urandom_range(0, 99) < (i < 300 ? 40 : 70), 0);
            if (almost_full) saw_af++;
        end
        step(0, '0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
